usb_uart_tx_arbiter: RTL
========================

# usb_uart_tx_arbiter

Round-robin, message-granular arbiter that shares the single transmit byte stream into `usb_uart` (`pipe_in`) among several on-chip requesters, for example the loopback echo path, a status reporter and a debug dumper. A requester that wins keeps the grant until it completes a byte flagged `last`, so messages never interleave. An optional idle timeout reclaims the grant from a requester that stalls mid-message. The arbiter sits between the requesters and the `usb_uart` instance in the 48 MHz domain.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `DATA_W`, default 8: byte width, matching the `PS_d8s` data field.
- `TIMEOUT`, default 4800: number of idle cycles allowed mid-message before the grant is revoked (100 µs at 48 MHz), legal range ≥2.

Ports:
- `clk_48mhz` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last` in N_REQ: marks the final byte of the current message.
- `req_ready` out N_REQ: per-requester accept.
- `out_valid` out 1: drives the `usb_uart` `pipe_in` valid.
- `out_data` out DATA_W: output byte.
- `out_last` out 1: passes through the granted requester's `req_last`.
- `out_ready` in 1: `pipe_in` ready from `usb_uart`.
- `grant` out N_REQ: one-hot registered grant, or all zeros when idle.
- `busy` out 1: high while in the LOCKED state.
- `timeout_evt` out 1: one-cycle pulse when a grant is revoked by the timeout.

## Operation
- There are two states, IDLE and LOCKED. The encodings live in the shared package.
- IDLE behaviour:
  - All `req_ready` are 0 and `out_valid` is 0.
  - If any `req_valid` is high, the arbiter picks the first requester with `req_valid` high, searching upward from `last_winner+1` modulo N_REQ.
  - It registers that requester into `grant` and enters LOCKED on the next edge.
- LOCKED behaviour, with granted index g:
  - Combinational pass-through: `out_valid`=`req_valid[g]`, `out_data`=`req_data[g]`, `out_last`=`req_last[g]`, `req_ready[g]`=`out_ready`.
  - All other `req_ready` are 0.
- Release: a handshake (`out_valid && out_ready`) with `out_last`=1 sets `last_winner`←g and moves the FSM to IDLE. `grant` clears on the same edge.
- A requester may drop `req_valid` mid-message. The grant is held, subject only to the timeout.
- Valid/ready compliance:
  - `grant` never changes while `out_valid && !out_ready`. Because the timeout counts only cycles where `req_valid[g]` is low, the requester's own valid/ready compliance guarantees this.
  - Requests that arrive while LOCKED wait; they are not lost and no request state is stored.
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - `last_winner` resets to N_REQ-1, so requester 0 has first priority after reset.
  - The idle counter resets to 0.
  - An assertion mid-message aborts the message immediately; no closing byte is emitted.

## Timing
- Arbitration latency is one cycle: a request seen in IDLE at edge k gives `grant` and `out_valid` at cycle k+1.
- Throughput is one byte per cycle while LOCKED. A release is followed by at least one IDLE cycle, so there is a one-cycle gap between messages.
- A single-byte message (`req_last`=1 on its first byte) holds LOCKED for exactly the handshake cycle.
- Timeout counter:
  - Width is clog2(TIMEOUT+1).
  - It increments each LOCKED cycle in which `req_valid[g]`=0.
  - It clears on any cycle with `req_valid[g]`=1, and on entry to LOCKED.
  - When it reaches TIMEOUT-1 and `req_valid[g]` is still 0, the FSM goes to IDLE on the next edge, `last_winner`←g, and `timeout_evt` pulses for that one cycle.
- Handshake with last versus timeout cannot coincide, because the timeout requires `req_valid[g]`=0.

## Configuration
- `USB_ARB_TIMEOUT_EN` defined: the idle counter and revocation logic above are present.
- `USB_ARB_TIMEOUT_EN` undefined:
  - There is no counter, and a grant is released only by a `last` handshake.
  - `timeout_evt` is tied to 0.
  - `TIMEOUT` is ignored.

## Structure
- The shared package (`usb_arb_pkg`) holds:
  - the state typedef/localparams `ARB_IDLE` and `ARB_LOCKED`;
  - the default `TIMEOUT_CYCLES_48MHZ`=4800.
- The sub-module `rr_pick` is purely combinational:
  - inputs: request vector and `last_winner`;
  - outputs: one-hot winner and a found flag;
  - parameterised by N_REQ.
- Everything else (FSM, grant register, mux, counter) lives in `usb_uart_tx_arbiter`.

## Test plan
- **Single requester:** req1 sends 0x41,0x42,0x0A with `last` on 0x0A, `out_ready`=1. Required: `out` shows the 3 bytes on consecutive cycles starting 1 cycle after `req_valid`; `grant`=4'b0010; then IDLE.
- **Rotation:** all 4 requesters hold 2-byte messages continuously. Required: grant order 0,1,2,3,0, with exactly one IDLE cycle between messages and no interleaved bytes.
- **Backpressure:** req2 is mid-message and `out_ready`=0 for 10 cycles. Required: `out_data` stays stable, `grant` is unchanged, other requests are held, and `req_ready[2]`=0.
- **Timeout:** with the macro defined and TIMEOUT=16, req0 sends 1 byte without `last`, then goes idle. Required: `timeout_evt` pulses exactly 16 cycles after the last handshake, and a pending req3 is granted on the next cycle. With the macro undefined, req0 keeps the grant indefinitely.
- **Reset mid-message:** assert `reset_n`=0 while req1 is LOCKED. Required: outputs are 0 asynchronously. After release, with req0 and req1 both valid, req0 wins.

Source files
------------

// File: rtl/usb_arb_pkg.sv
// Shared definitions for the usb_uart transmit arbiter.
// Feature macro: USB_ARB_TIMEOUT_EN enables the mid-message idle timeout.
package usb_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // 100 us of idle at 48 MHz
  localparam int unsigned TIMEOUT_CYCLES_48MHZ = 4800;

  // Legal requester count range
  localparam int unsigned ARB_MIN_REQ = 2;
  localparam int unsigned ARB_MAX_REQ = 8;

  // Shortest timeout the revocation logic supports
  localparam int unsigned ARB_MIN_TIMEOUT = 2;

  // Index width for a requester vector, never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_winner, wrapping modulo N_REQ; the previous winner is checked last.
module rr_pick
  import usb_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] winner,
  output logic             found
);

  logic [IDX_W-1:0] idx;

  // Walk the ring starting one past the previous winner
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((32'(last_winner) + k) % N_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding the usb_uart pipe_in stream.
// A winner keeps the grant until it hands over a byte flagged last.
// Feature macro: USB_ARB_TIMEOUT_EN adds an idle counter that revokes a grant
// from a requester that stalls mid-message for TIMEOUT cycles.
module usb_uart_tx_arbiter
  import usb_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_CYCLES_48MHZ
) (
  input  logic                    clk_48mhz,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    timeout_evt
);

  localparam int unsigned IDX_W = idx_w(N_REQ);

  // Elaboration-time parameter legality
  if ((N_REQ < ARB_MIN_REQ) || (N_REQ > ARB_MAX_REQ)) begin : g_bad_n_req
    $error("usb_uart_tx_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT < ARB_MIN_TIMEOUT) begin : g_bad_timeout
    $error("usb_uart_tx_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_winner_q, last_winner_d;
  logic             timeout_evt_q, timeout_evt_d;

  logic [N_REQ-1:0] pick_winner;
  logic             pick_found;
  logic [IDX_W-1:0] grant_idx;
  logic             hs_last;
  logic             timeout_hit;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req         (req_valid),
    .last_winner (last_winner_q),
    .winner      (pick_winner),
    .found       (pick_found)
  );

  // Encode the one-hot grant as an index for last_winner bookkeeping
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  // Pass-through of the granted requester; everything is zero while idle
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        out_valid    = req_valid[i];
        out_data     = req_data[i*DATA_W +: DATA_W];
        out_last     = req_last[i];
        req_ready[i] = out_ready;
      end
    end
  end

  assign hs_last = out_valid & out_ready & out_last;

`ifdef USB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // Count consecutive idle cycles of the granted requester while locked
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if ((state_q == ARB_LOCKED) && !out_valid) begin
      if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end
  end

  // Idle counter register
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  // Without the timeout a grant is released only by a last handshake
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, release on last or on timeout
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_winner_d = last_winner_q;
    timeout_evt_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_LOCKED;
          grant_d = pick_winner;
        end
      end
      ARB_LOCKED: begin
        if (hs_last) begin
          state_d       = ARB_IDLE;
          grant_d       = '0;
          last_winner_d = grant_idx;
        end else if (timeout_hit) begin
          state_d       = ARB_IDLE;
          grant_d       = '0;
          last_winner_d = grant_idx;
          timeout_evt_d = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // FSM, grant and round-robin pointer registers
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      last_winner_q <= IDX_W'(N_REQ - 1);
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_winner_q <= last_winner_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == ARB_LOCKED);
  assign timeout_evt = timeout_evt_q;

endmodule
